// File: rtl/hls_key_loader.sv
// Key loader in front of the locked HLS core: collects the working key as a word stream, verifies a
// trailing XOR checksum, and only then exposes the key and lets ap_start through to the core.
module hls_key_loader #(
    parameter int KEY_WIDTH = 3071,
    parameter int WORD_W    = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [WORD_W-1:0]    key_data,
    input  logic                 key_vld,
    output logic                 key_rdy,
    input  logic                 key_clear,
    input  logic                 ap_start,
    output logic                 core_ap_start,
    input  logic                 core_ap_idle,
    output logic [KEY_WIDTH-1:0] working_key,
    output logic                 key_ready,
    output logic                 key_error,
    output logic [1:0]           dbg_state
);

    localparam int NWORDS = (KEY_WIDTH + WORD_W - 1) / WORD_W;
    localparam int CW     = $clog2(NWORDS + 1);
    localparam int TAIL   = KEY_WIDTH - (NWORDS - 1) * WORD_W;
    localparam logic [WORD_W-1:0] TAIL_MASK = {WORD_W{1'b1}} >> (WORD_W - TAIL);

    typedef enum logic [1:0] {LOAD, CHK, READY, ERR} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic [KEY_WIDTH-1:0] shadow;
    logic [WORD_W-1:0]   csum;
    logic                clear_pending;

    logic                xfer;
    logic                last_word;
    logic [WORD_W-1:0]   word_in;
    logic                csum_match;
    logic                do_clear;

    // Handshake: a word moves on the rising ap_clk where key_vld & key_rdy; the source holds key_data
    // stable while key_vld=1 and key_rdy=0. key_rdy depends only on state and ap_rst, never on key_vld.
    assign key_rdy    = !ap_rst && (state == LOAD || state == CHK);
    assign xfer       = key_vld && key_rdy;
    assign last_word  = (cnt == CW'(NWORDS - 1));
    assign word_in    = last_word ? (key_data & TAIL_MASK) : key_data;
    assign csum_match = (key_data == csum);

    // A clear in READY waits for the core to be idle so a running core is never re-keyed.
    assign do_clear = (state == READY) ? ((key_clear || clear_pending) && core_ap_idle) : key_clear;

    assign key_ready     = (state == READY);
    assign key_error     = (state == ERR);
    assign core_ap_start = !ap_rst && (state == READY) && ap_start && !key_clear && !clear_pending;
    assign dbg_state     = state;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state <= LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (do_clear) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                LOAD:    if (xfer && last_word) state_nxt = CHK;
                CHK:     if (xfer) state_nxt = csum_match ? READY : ERR;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst || do_clear) begin
            cnt           <= '0;
            shadow        <= '0;
            csum          <= '0;
            working_key   <= '0;
            clear_pending <= 1'b0;
        end else begin
            if (state == READY && key_clear && !core_ap_idle) begin
                clear_pending <= 1'b1;
            end
            if (xfer && state == LOAD) begin
                // Bits of the final word beyond KEY_WIDTH have no shadow storage and are dropped here.
                for (int k = 0; k < KEY_WIDTH; k++) begin
                    if (cnt == CW'(k / WORD_W)) shadow[k] <= key_data[k % WORD_W];
                end
                csum <= csum ^ word_in;
                cnt  <= cnt + CW'(1);
            end
            if (xfer && state == CHK && csum_match) begin
                working_key <= shadow;
            end
        end
    end

endmodule
